// File: rtl/layer_sequencer.sv
// Layer sequencer: drives matmul -> bias add -> sigmoid for each of L network layers,
// qualifies engine done levels against stale highs, and guards every engine wait with a
// watchdog that parks the FSM in an error state.
module layer_sequencer #(
  parameter int unsigned L   = 2,
  parameter int unsigned TMO = 4096,
  localparam int unsigned LW = (L > 1) ? $clog2(L) : 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,      // active-high synchronous reset despite the name
  input  logic          start_i,
  input  logic          mul_done_i,
  input  logic          add_done_i,
  input  logic          sig_done_i,
  output logic          mul_start_o,
  output logic          add_start_o,
  output logic          sig_start_o,
  output logic [LW-1:0] layer_idx_o,
  output logic          sel_in_o,
  output logic          load_out_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned CW = $clog2(TMO);
  localparam logic [LW-1:0] LastLayer = LW'(L - 1);
  localparam logic [CW-1:0] TmoLast   = CW'(TMO - 1);

  typedef enum logic [3:0] {
    StIdle, StMulGo, StMulWait, StAddGo, StAddWait, StSigGo, StSigWait, StNext, StDone, StErr
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          arm_q, arm_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          eng_done;
  logic          qual_done;
  logic          in_engine;
  logic          to_go;

  // Select the done level of the engine owned by the current state; others are ignored.
  always_comb begin
    eng_done = 1'b0;
    unique case (state_q)
      StMulGo, StMulWait: eng_done = mul_done_i;
      StAddGo, StAddWait: eng_done = add_done_i;
      StSigGo, StSigWait: eng_done = sig_done_i;
      default:            eng_done = 1'b0;
    endcase
  end

  // Next state, layer index, arm flag and watchdog counter.
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    arm_d     = arm_q;
    wdog_d    = wdog_q;
    // A done only counts once the engine has been seen low since its start pulse.
    qual_done = arm_q & eng_done;

    unique case (state_q)
      StIdle:    state_d = StIdle;
      StMulGo:   state_d = StMulWait;
      StMulWait: begin
        if (qual_done)             state_d = StAddGo;
        else if (wdog_q == TmoLast) state_d = StErr;
      end
      StAddGo:   state_d = StAddWait;
      StAddWait: begin
        if (qual_done)             state_d = StSigGo;
        else if (wdog_q == TmoLast) state_d = StErr;
      end
      StSigGo:   state_d = StSigWait;
      StSigWait: begin
        if (qual_done)             state_d = StNext;
        else if (wdog_q == TmoLast) state_d = StErr;
      end
      StNext: begin
        if (layer_q == LastLayer) begin
          state_d = StDone;
        end else begin
          layer_d = layer_q + LW'(1);
          state_d = StMulGo;
        end
      end
      StDone:    state_d = StIdle;
      StErr:     state_d = StErr;
      default:   state_d = StIdle;
    endcase

    // Start aborts whatever is in flight and restarts from layer 0.
    if (start_i) begin
      state_d = StMulGo;
      layer_d = '0;
    end

    in_engine = state_q inside {StMulGo, StMulWait, StAddGo, StAddWait, StSigGo, StSigWait};
    to_go     = state_d inside {StMulGo, StAddGo, StSigGo};

    if (in_engine) begin
      arm_d  = arm_q | ~eng_done;
      wdog_d = wdog_q + CW'(1);
    end
    // Entering a GO state starts a fresh operation: forget old arming and timing.
    if (to_go) begin
      arm_d  = 1'b0;
      wdog_d = '0;
    end
  end

  // State registers with synchronous reset taking priority over start.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q <= StIdle;
      layer_q <= '0;
      arm_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      arm_q   <= arm_d;
      wdog_q  <= wdog_d;
    end
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    mul_start_o = (state_q == StMulGo);
    add_start_o = (state_q == StAddGo);
    sig_start_o = (state_q == StSigGo);
    load_out_o  = (state_q == StNext);
    done_o      = (state_q == StDone);
    err_o       = (state_q == StErr);
    busy_o      = !(state_q inside {StIdle, StDone, StErr});
    layer_idx_o = layer_q;
    sel_in_o    = (layer_q != '0);
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes expected output events, a monitor
// pops and compares each observed pulse / err edge. Instance a: L=2, instance b: L=1.
module tb_layer_sequencer;

  localparam logic [2:0] KMul = 3'd0, KAdd = 3'd1, KSig = 3'd2, KLoad = 3'd3,
                         KDone = 3'd4, KErrRise = 3'd5, KErrFall = 3'd6;

  typedef struct packed {
    logic [1:0]  id;
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic        layer;
    logic        sel;
    logic        busy;
  } ev_t;

  logic        clk = 1'b0;
  logic [31:0] cyc = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  ev_t         sb_q[$];
  int unsigned s, e;

  // Instance a stimulus / responses
  logic rst_a, start_a, mul_force, add_en;
  logic mul_resp_a = 1'b0, add_resp_a = 1'b0, sig_resp_a = 1'b0;
  logic mul_done_a, add_done_a, sig_done_a;
  logic mul_start_a, add_start_a, sig_start_a, sel_in_a, load_out_a, busy_a, done_a, err_a;
  logic [0:0] layer_a;
  // Instance b
  logic rst_b, start_b;
  logic mul_resp_b = 1'b0, add_resp_b = 1'b0, sig_resp_b = 1'b0;
  logic mul_start_b, add_start_b, sig_start_b, sel_in_b, load_out_b, busy_b, done_b, err_b;
  logic [0:0] layer_b;
  logic err_q_a = 1'b0, err_q_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Engines: done low during the start-pulse cycle, high for the following cycle.
  always @(posedge clk) begin
    mul_resp_a <= mul_start_a;
    add_resp_a <= add_start_a & add_en;
    sig_resp_a <= sig_start_a;
    mul_resp_b <= mul_start_b;
    add_resp_b <= add_start_b;
    sig_resp_b <= sig_start_b;
  end
  assign mul_done_a = mul_resp_a | mul_force;
  assign add_done_a = add_resp_a;
  assign sig_done_a = sig_resp_a;

  layer_sequencer #(.L(2), .TMO(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .start_i(start_a),
    .mul_done_i(mul_done_a), .add_done_i(add_done_a), .sig_done_i(sig_done_a),
    .mul_start_o(mul_start_a), .add_start_o(add_start_a), .sig_start_o(sig_start_a),
    .layer_idx_o(layer_a), .sel_in_o(sel_in_a), .load_out_o(load_out_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  layer_sequencer #(.L(1), .TMO(16)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .start_i(start_b),
    .mul_done_i(mul_resp_b), .add_done_i(add_resp_b), .sig_done_i(sig_resp_b),
    .mul_start_o(mul_start_b), .add_start_o(add_start_b), .sig_start_o(sig_start_b),
    .layer_idx_o(layer_b), .sel_in_o(sel_in_b), .load_out_o(load_out_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  task automatic push(input int id, input logic [2:0] kind, input int unsigned c,
                      input int layer, input logic busy);
    ev_t ev;
    ev.id = 2'(id); ev.kind = kind; ev.cyc = c; ev.layer = 1'(layer);
    ev.sel = (layer != 0); ev.busy = busy;
    sb_q.push_back(ev);
  endtask

  // Expected events of an undisturbed pass whose start is sampled at the end of cycle st.
  task automatic push_pass(input int id, input int unsigned st, input int nl);
    for (int l = 0; l < nl; l++) begin
      push(id, KMul,  st + 1 + 7 * l, l, 1'b1);
      push(id, KAdd,  st + 3 + 7 * l, l, 1'b1);
      push(id, KSig,  st + 5 + 7 * l, l, 1'b1);
      push(id, KLoad, st + 7 + 7 * l, l, 1'b1);
    end
    push(id, KDone, st + 7 * nl + 1, nl - 1, 1'b0);
  endtask

  task automatic see(input int id, input logic [2:0] kind, input logic layer, input logic sel,
                     input logic busy);
    ev_t got, exp;
    got.id = 2'(id); got.kind = kind; got.cyc = cyc; got.layer = layer; got.sel = sel;
    got.busy = busy;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event dut=%0d kind=%0d cyc=%0d (none required)", id, kind, cyc);
    end else begin
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL event: got dut=%0d kind=%0d cyc=%0d layer=%0d sel=%0d busy=%0d, required dut=%0d kind=%0d cyc=%0d layer=%0d sel=%0d busy=%0d",
                 got.id, got.kind, got.cyc, got.layer, got.sel, got.busy,
                 exp.id, exp.kind, exp.cyc, exp.layer, exp.sel, exp.busy);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic go_to(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every observed pulse or err edge is matched against the scoreboard.
  always @(negedge clk) begin
    if (err_q_a && !err_a) see(0, KErrFall, layer_a, sel_in_a, busy_a);
    if (!err_q_a && err_a) see(0, KErrRise, layer_a, sel_in_a, busy_a);
    if (mul_start_a)       see(0, KMul,     layer_a, sel_in_a, busy_a);
    if (add_start_a)       see(0, KAdd,     layer_a, sel_in_a, busy_a);
    if (sig_start_a)       see(0, KSig,     layer_a, sel_in_a, busy_a);
    if (load_out_a)        see(0, KLoad,    layer_a, sel_in_a, busy_a);
    if (done_a)            see(0, KDone,    layer_a, sel_in_a, busy_a);
    if (err_q_b && !err_b) see(1, KErrFall, layer_b, sel_in_b, busy_b);
    if (!err_q_b && err_b) see(1, KErrRise, layer_b, sel_in_b, busy_b);
    if (mul_start_b)       see(1, KMul,     layer_b, sel_in_b, busy_b);
    if (add_start_b)       see(1, KAdd,     layer_b, sel_in_b, busy_b);
    if (sig_start_b)       see(1, KSig,     layer_b, sel_in_b, busy_b);
    if (load_out_b)        see(1, KLoad,    layer_b, sel_in_b, busy_b);
    if (done_b)            see(1, KDone,    layer_b, sel_in_b, busy_b);
    err_q_a <= err_a;
    err_q_b <= err_b;
  end

  initial begin
    rst_a = 1'b1; start_a = 1'b1; rst_b = 1'b1; start_b = 1'b1;
    mul_force = 1'b0; add_en = 1'b1;
    repeat (3) @(negedge clk);
    // Reset held with start high: everything quiet.
    chk("reset_outputs_a", 32'({mul_start_a, add_start_a, sig_start_a, load_out_a, busy_a,
                                done_a, err_a, sel_in_a, layer_a}), 32'd0);
    chk("reset_outputs_b", 32'({mul_start_b, add_start_b, sig_start_b, load_out_b, busy_b,
                                done_b, err_b, sel_in_b, layer_b}), 32'd0);
    rst_a = 1'b0; start_a = 1'b0; rst_b = 1'b0; start_b = 1'b0;
    @(negedge clk);

    // Minimum-latency two-layer pass.
    s = cyc; start_a = 1'b1; push_pass(0, s, 2);
    @(negedge clk); start_a = 1'b0;
    go_to(s + 18);
    chk("layer_hold_after_done", 32'({busy_a, layer_a, sel_in_a}), 32'b011);

    // mul_done stuck high from before start: must see it low, then high.
    mul_force = 1'b1;
    s = cyc; start_a = 1'b1;
    push(0, KMul, s + 1, 0, 1'b1);
    push(0, KAdd, s + 7, 0, 1'b1);
    push(0, KSig, s + 9, 0, 1'b1);
    push(0, KLoad, s + 11, 0, 1'b1);
    push(0, KMul, s + 12, 1, 1'b1);
    push(0, KAdd, s + 14, 1, 1'b1);
    push(0, KSig, s + 16, 1, 1'b1);
    push(0, KLoad, s + 18, 1, 1'b1);
    push(0, KDone, s + 19, 1, 1'b0);
    @(negedge clk); start_a = 1'b0;
    go_to(s + 5); mul_force = 1'b0;
    go_to(s + 6); mul_force = 1'b1;
    go_to(s + 7); mul_force = 1'b0;
    go_to(s + 21);

    // Watchdog: add engine never answers; ERR 16 cycles after ADD_GO.
    add_en = 1'b0;
    s = cyc; start_a = 1'b1;
    push(0, KMul, s + 1, 0, 1'b1);
    push(0, KAdd, s + 3, 0, 1'b1);
    push(0, KErrRise, s + 19, 0, 1'b0);
    @(negedge clk); start_a = 1'b0;
    go_to(s + 22);
    chk("err_sticky", 32'({err_a, busy_a, mul_start_a}), 32'b100);
    add_en = 1'b1;
    e = cyc; start_a = 1'b1;
    push(0, KErrFall, e + 1, 0, 1'b1);
    push_pass(0, e, 2);
    @(negedge clk); start_a = 1'b0;
    go_to(e + 17);

    // Restart during layer-1 SIG_WAIT: no load_out for the aborted layer.
    s = cyc; start_a = 1'b1;
    push(0, KMul, s + 1, 0, 1'b1);
    push(0, KAdd, s + 3, 0, 1'b1);
    push(0, KSig, s + 5, 0, 1'b1);
    push(0, KLoad, s + 7, 0, 1'b1);
    push(0, KMul, s + 8, 1, 1'b1);
    push(0, KAdd, s + 10, 1, 1'b1);
    push(0, KSig, s + 12, 1, 1'b1);
    @(negedge clk); start_a = 1'b0;
    go_to(s + 13); start_a = 1'b1;
    push_pass(0, s + 13, 2);
    @(negedge clk); start_a = 1'b0;
    chk("abort_restart_layer", 32'({mul_start_a, layer_a, sel_in_a}), 32'b100);
    go_to(s + 31);

    // Reset with start during ADD_WAIT: reset wins, no further pulses.
    s = cyc; start_a = 1'b1;
    push(0, KMul, s + 1, 0, 1'b1);
    push(0, KAdd, s + 3, 0, 1'b1);
    @(negedge clk); start_a = 1'b0;
    go_to(s + 4); rst_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    chk("reset_mid_pass", 32'({mul_start_a, add_start_a, sig_start_a, load_out_a, busy_a,
                               done_a, err_a, sel_in_a, layer_a}), 32'd0);
    rst_a = 1'b0; start_a = 1'b0;
    go_to(s + 12);

    // Single-layer instance: done 8 cycles after start, sel_in stays 0.
    s = cyc; start_b = 1'b1; push_pass(1, s, 1);
    @(negedge clk); start_b = 1'b0;
    go_to(s + 11);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter L, default 2: number of network layers to sequence (L >= 1).
REQ-002 Parameter TMO, default 4096: watchdog limit, in cycles, for any single engine wait (TMO >= 2).
REQ-003 Local width LW = max(1, clog2(L)).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-high: 1 = reset, sampled on clk.
REQ-006 start  input  1  begin (or restart) a full L-layer pass.
REQ-007 mul_done  input  1  done level from the matmul engine.
REQ-008 add_done  input  1  done level from the vector bias adder.
REQ-009 sig_done  input  1  done level from the sigmoid engine.
REQ-010 mul_start  output  1  one-cycle start pulse to the matmul engine.
REQ-011 add_start  output  1  one-cycle start pulse to the bias adder.
REQ-012 sig_start  output  1  one-cycle start pulse to the sigmoid engine.
REQ-013 layer_idx  output  LW  layer currently in progress; selects weight/bias bank.
REQ-014 sel_in  output  1  input mux select: 0 = external x, 1 = previous layer output register.
REQ-015 load_out  output  1  one-cycle pulse: capture sigmoid output into the layer output register.
REQ-016 busy  output  1  high in every state except IDLE, DONE, ERR.
REQ-017 done  output  1  one-cycle pulse when all L layers complete.
REQ-018 err  output  1  sticky watchdog error flag.

Function
REQ-019 All outputs SHALL be registered (Moore): decoded from the current state and counters, with no combinational path from any input.
REQ-020 States: IDLE, MUL_GO, MUL_WAIT, ADD_GO, ADD_WAIT, SIG_GO, SIG_WAIT, NEXT, DONE, ERR.
REQ-021 x_start SHALL be 1 only in the matching x_GO state, lasting exactly one cycle; every x_GO SHALL transition unconditionally to x_WAIT.
REQ-022 Stale-done qualification: an arm flag SHALL be cleared on entry to each x_GO and set on any cycle in x_GO or x_WAIT where the matching done input is 0.
REQ-023 x_WAIT SHALL exit only on a cycle where the arm flag (registered value) is 1 and the done input is 1; done held high from a previous operation SHALL NOT count.
REQ-024 Transitions: IDLE -> MUL_GO on start; MUL_WAIT -> ADD_GO; ADD_WAIT -> SIG_GO; SIG_WAIT -> NEXT.
REQ-025 NEXT SHALL assert load_out for one cycle; then go to DONE if layer_idx == L-1, else increment layer_idx and go to MUL_GO.
REQ-026 DONE SHALL assert done for one cycle, then go to IDLE; layer_idx SHALL hold L-1 until the next start.
REQ-027 sel_in SHALL equal 0 while layer_idx == 0, else 1.
REQ-028 Watchdog: a cycle counter SHALL clear on entry to each x_GO and increment in x_WAIT; reaching TMO-1 without a qualified done SHALL cause the transition to ERR on the next edge.
REQ-029 ERR SHALL set err = 1 and hold until start or reset; no start pulses are issued in ERR.
REQ-030 start in any state (including mid-pass, DONE or ERR) SHALL take priority: clear err, set layer_idx = 0, and go to MUL_GO on the next edge (abort and restart).
REQ-031 A done input rising in a state other than its own x_GO/x_WAIT SHALL be ignored.
REQ-032 Minimum pass latency SHALL be L*7 + 1 cycles from start sampled to done pulse: 2 per engine, plus NEXT, plus DONE.

Reset
REQ-033 While rst_n = 1: state = IDLE, layer_idx = 0, arm flag = 0, watchdog counter = 0.
REQ-034 While rst_n = 1: all start pulses, load_out, busy, done and err SHALL be 0, and sel_in = 0.
REQ-035 Reset SHALL override start; reset mid-pass SHALL abort without further pulses.

Verification
REQ-036 L=2, engines respond with done low 1 cycle then high: start at cycle 0 -> pulse order mul,add,sig,load_out (layer 0), then mul,add,sig,load_out (layer 1), done at cycle 15, sel_in 0 then 1.
REQ-037 Engine done held high from a prior operation: mul_done stuck 1 through MUL_GO -> no exit until mul_done seen 0 then 1.
REQ-038 TMO=16, add_done never asserted -> err = 1 exactly 16 cycles after ADD_GO; busy = 0; start clears err and mul_start pulses next cycle.
REQ-039 start asserted during layer 1 SIG_WAIT -> next cycle MUL_GO, layer_idx = 0, sel_in = 0, no load_out for the aborted layer.
REQ-040 rst_n = 1 during ADD_WAIT together with start -> next cycle all outputs 0 and state IDLE; no start pulse issued.
REQ-041 L=1 -> sel_in stays 0 throughout; done pulses 8 cycles after start under minimum-latency engine responses.
